// File: rtl/timer_multi_ch_if.sv
// Bus bundle for timer_multi_ch: per-channel controls and configuration in, status out.
interface timer_multi_ch_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PSC_W  = 16
);
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       up_down;
  logic [NUM_CH-1:0]       one_shot;
  logic [NUM_CH*PSC_W-1:0] prescaler;
  logic [NUM_CH*CNT_W-1:0] load;
  logic [NUM_CH*CNT_W-1:0] compare;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       running;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       pwm;

  modport master (
    output en, start, stop, up_down, one_shot, prescaler, load, compare,
    input  tick, running, count, pwm
  );

  modport slave (
    input  en, start, stop, up_down, one_shot, prescaler, load, compare,
    output tick, running, count, pwm
  );
endinterface

// File: rtl/timer_multi_ch.sv
// Multi-channel prescaled up/down timer with one-shot/periodic modes and optional PWM.
// Define TIMER_PWM_EN to build the per-channel compare output; otherwise pwm is tied to 0.
//
// state   | meaning
// ST_IDLE | channel stopped, count held
// ST_RUN  | channel counting (when en) through the prescaler
module timer_multi_ch #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PSC_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  timer_multi_ch_if.slave  bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] load_i;
    logic [PSC_W-1:0] psc_lim;
    logic             up;
    logic             step;
    logic             at_term;

    assign load_i  = bus.load[g*CNT_W +: CNT_W];
    assign psc_lim = bus.prescaler[g*PSC_W +: PSC_W];
    assign up      = bus.up_down[g];
    assign step    = (psc_q >= psc_lim);
    // Terminal test guards both ends, so the counter can never wrap.
    assign at_term = up ? (cnt_q >= load_i) : (cnt_q == '0);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      psc_d   = psc_q;
      tick_d  = 1'b0;
      if (bus.stop[g]) begin
        state_d = ST_IDLE;
      end else if (bus.start[g]) begin
        state_d = ST_RUN;
        psc_d   = '0;
        cnt_d   = up ? '0 : load_i;
      end else if (state_q == ST_RUN && bus.en[g]) begin
        if (step) begin
          psc_d = '0;
          if (at_term) begin
            tick_d = 1'b1;
            if (bus.one_shot[g]) begin
              state_d = ST_IDLE;
            end else begin
              cnt_d = up ? '0 : load_i;
            end
          end else begin
            cnt_d = up ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
          end
        end else begin
          psc_d = psc_q + PSC_W'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        psc_q   <= '0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        psc_q   <= psc_d;
        tick_q  <= tick_d;
      end
    end

    assign bus.tick[g]                  = tick_q;
    assign bus.running[g]               = (state_q == ST_RUN);
    assign bus.count[g*CNT_W +: CNT_W]  = cnt_q;
`ifdef TIMER_PWM_EN
    assign bus.pwm[g] = (state_q == ST_RUN) && (cnt_q < bus.compare[g*CNT_W +: CNT_W]);
`else
    assign bus.pwm[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_timer_multi_ch.sv
// Self-checking bench for timer_multi_ch: directed scenarios plus randomized rounds
// checked every cycle against a closed-form model based on elapsed enabled cycles.
module tb_timer_multi_ch;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int PSC_W  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_multi_ch_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PSC_W(PSC_W)) bus ();

  timer_multi_ch #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // stimulus configuration
  int c_psc [NUM_CH];
  int c_load[NUM_CH];
  int c_cmp [NUM_CH];
  bit c_en  [NUM_CH];
  bit c_start[NUM_CH];
  bit c_stop[NUM_CH];
  bit c_up  [NUM_CH];
  bit c_os  [NUM_CH];

  // reference model state
  bit m_run [NUM_CH];
  int m_el  [NUM_CH];
  int m_cnt [NUM_CH];
  bit m_tick[NUM_CH];

  task automatic drive();
    for (int i = 0; i < NUM_CH; i++) begin
      bus.en[i]       = c_en[i];
      bus.start[i]    = c_start[i];
      bus.stop[i]     = c_stop[i];
      bus.up_down[i]  = c_up[i];
      bus.one_shot[i] = c_os[i];
      bus.prescaler[i*PSC_W +: PSC_W] = PSC_W'(c_psc[i]);
      bus.load[i*CNT_W +: CNT_W]      = CNT_W'(c_load[i]);
      bus.compare[i*CNT_W +: CNT_W]   = CNT_W'(c_cmp[i]);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) begin
      m_run[i] = 0; m_el[i] = 0; m_cnt[i] = 0; m_tick[i] = 0;
    end
  endtask

  // Count after n enabled cycles follows from the number of whole prescaler periods.
  task automatic model_edge();
    for (int i = 0; i < NUM_CH; i++) begin
      m_tick[i] = 0;
      if (c_stop[i]) begin
        m_run[i] = 0;
      end else if (c_start[i]) begin
        m_run[i] = 1;
        m_el[i]  = 0;
        m_cnt[i] = c_up[i] ? 0 : c_load[i];
      end else if (m_run[i] && c_en[i]) begin
        int per, steps;
        m_el[i]++;
        per   = (c_load[i] + 1) * (c_psc[i] + 1);
        steps = m_el[i] / (c_psc[i] + 1);
        m_tick[i] = (m_el[i] % per) == 0;
        if (m_tick[i] && c_os[i]) begin
          m_run[i] = 0;
          m_cnt[i] = c_up[i] ? c_load[i] : 0;
        end else if (c_up[i]) begin
          m_cnt[i] = steps % (c_load[i] + 1);
        end else begin
          m_cnt[i] = c_load[i] - (steps % (c_load[i] + 1));
        end
      end
    end
  endtask

  task automatic check(input string tag);
    logic [NUM_CH-1:0]       e_tick, e_run, e_pwm;
    logic [NUM_CH*CNT_W-1:0] e_cnt;
    for (int i = 0; i < NUM_CH; i++) begin
      e_tick[i] = m_tick[i];
      e_run[i]  = m_run[i];
      e_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
`ifdef TIMER_PWM_EN
      e_pwm[i] = m_run[i] && (m_cnt[i] < c_cmp[i]);
`else
      e_pwm[i] = 1'b0;
`endif
    end
    vectors++;
    assert (bus.tick === e_tick) else begin
      miscompares++;
      $error("FAIL %s tick: observed %b expected %b at %0t", tag, bus.tick, e_tick, $time);
    end
    vectors++;
    assert (bus.running === e_run) else begin
      miscompares++;
      $error("FAIL %s running: observed %b expected %b at %0t", tag, bus.running, e_run, $time);
    end
    vectors++;
    assert (bus.count === e_cnt) else begin
      miscompares++;
      $error("FAIL %s count: observed %h expected %h at %0t", tag, bus.count, e_cnt, $time);
    end
    vectors++;
    assert (bus.pwm === e_pwm) else begin
      miscompares++;
      $error("FAIL %s pwm: observed %b expected %b at %0t", tag, bus.pwm, e_pwm, $time);
    end
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check(tag);
    for (int i = 0; i < NUM_CH; i++) begin
      c_start[i] = 0;
      c_stop[i]  = 0;
    end
    drive();
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      c_psc[i] = 0; c_load[i] = 0; c_cmp[i] = 0;
      c_en[i] = 0; c_start[i] = 0; c_stop[i] = 0; c_up[i] = 0; c_os[i] = 0;
    end
    drive();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset");
    rst = 1'b0;

    // ch0 down periodic, prescaler 9, load 16: tick every 170 cycles
    c_psc[0] = 9; c_load[0] = 16; c_up[0] = 0; c_os[0] = 0; c_en[0] = 1; c_cmp[0] = 5;
    c_start[0] = 1; drive();
    run(400, "t1_down_periodic");

    // ch1 up one-shot, prescaler 0, load 5
    c_psc[1] = 0; c_load[1] = 5; c_up[1] = 1; c_os[1] = 1; c_en[1] = 1; c_cmp[1] = 2;
    c_start[1] = 1; drive();
    run(20, "t2_up_oneshot");

    // ch0 frozen by en for 50 cycles
    c_en[0] = 0; drive();
    run(50, "t3_freeze");
    c_en[0] = 1; drive();
    run(120, "t3_resume");

    // start+stop together on an idle channel, then restart ch0 mid-count
    c_psc[2] = 1; c_load[2] = 7; c_en[2] = 1;
    c_start[2] = 1; c_stop[2] = 1; drive();
    run(5, "t4_start_stop");
    c_start[0] = 1; drive();
    run(30, "t4_restart");

    // asynchronous reset mid-run
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check("t4_async_reset");
    @(posedge clk);
    #1;
    check("t4_reset_held");
    rst = 1'b0;
    run(3, "t4_after_reset");

    // four channels, prescaler 0..3, load 3: periods 4/8/12/16
    for (int i = 0; i < NUM_CH; i++) begin
      c_psc[i] = i; c_load[i] = 3; c_up[i] = 0; c_os[i] = 0; c_en[i] = 1; c_cmp[i] = 2;
      c_start[i] = 1;
    end
    drive();
    run(70, "t5_multi");

    // ch3 up, prescaler 0, load 9, compare 3, then compare 0
    c_psc[3] = 0; c_load[3] = 9; c_up[3] = 1; c_os[3] = 0; c_cmp[3] = 3; c_start[3] = 1;
    drive();
    run(30, "t6_pwm3");
    c_cmp[3] = 0; drive();
    run(15, "t6_pwm0");
    c_cmp[3] = 12; drive();
    run(15, "t6_pwm_full");

    // randomized rounds
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        c_psc[i]  = $urandom_range(0, 4);
        c_load[i] = $urandom_range(0, 12);
        c_cmp[i]  = $urandom_range(0, 14);
        c_up[i]   = 1'($urandom_range(0, 1));
        c_os[i]   = 1'($urandom_range(0, 1));
        c_en[i]   = 1;
        c_start[i] = 1;
      end
      drive();
      cycle("rand_start");
      for (int k = 0; k < 150; k++) begin
        for (int i = 0; i < NUM_CH; i++) begin
          c_en[i] = ($urandom_range(0, 7) != 0);
          if ($urandom_range(0, 63) == 0) c_stop[i] = 1;
          if ($urandom_range(0, 63) == 0) c_start[i] = 1;
        end
        drive();
        cycle("rand_run");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
